imm_gen_pipe: RTL and testbench

//  Registered, parametrised immediate generator for the decode stage.
//  - Takes an instruction, its ImmSrc format code and a sideband tag (PC).
//  - Returns the XLEN-wide extended immediate one cycle later through a valid/ready skid buffer.
//  - Flags unsupported format codes in hardware and counts them.
//  - Sits between the fetch/decode pipeline register and the ALU operand mux.

---
 rtl/imm_gen_pipe.sv | 128 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a valid/ready skid buffer and a saturating bad-format counter.
// Define IMMGEN_ZIMM_EN to decode ImmSrc=101 as the CSR zimm format; otherwise 101 is flagged unsupported.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmOp,
    output logic [TAG_W-1:0] tag_out,
    output logic             imm_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_U = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;
`ifdef IMMGEN_ZIMM_EN
    localparam logic [2:0] SRC_Z = 3'b101;
`endif

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } item_t;

    logic [31:0]      imm32;
    logic             new_err;
    item_t            new_item;
    logic             accept;
    logic             unused_instr_bits;

    item_t            main_q, main_d;
    logic             main_valid_q, main_valid_d;
    item_t            skid_q, skid_d;
    logic             skid_full_q, skid_full_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign unused_instr_bits = ^instr[6:0];

    // 32-bit immediate per format; every format carries its sign in bit 31 (zimm has it clear)
    always_comb begin
        imm32   = '0;
        new_err = 1'b0;
        case (ImmSrc)
            SRC_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            SRC_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            SRC_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            SRC_U:   imm32 = {instr[31:12], 12'b0};
            SRC_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMMGEN_ZIMM_EN
            SRC_Z:   imm32 = {27'b0, instr[19:15]};
`endif
            default: new_err = 1'b1;
        endcase
    end

    assign new_item.imm = XLEN'($signed(imm32));
    assign new_item.tag = tag_in;
    assign new_item.err = new_err;
    assign accept       = in_valid && in_ready_q;

    // Skid control: main drains or refills from skid; a held main pushes new arrivals into skid
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_full_d  = skid_full_q;
        err_cnt_d    = err_cnt_q;
        if (!main_valid_q || out_ready) begin
            if (skid_full_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_full_d  = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = new_item;
                end
            end
        end else if (accept) begin
            skid_d      = new_item;
            skid_full_d = 1'b1;
        end
        if (accept && new_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        in_ready_d = !skid_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_full_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            err_cnt_q    <= '0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_full_q  <= skid_full_d;
            in_ready_q   <= in_ready_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign ImmOp     = main_q.imm;
    assign tag_out   = main_q.tag;
    assign imm_err   = main_q.err;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed bench for imm_gen_pipe; XLEN=32 and XLEN=64 instances share stimulus
// and are checked against a queue-based reference of the pipe contents.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  ImmSrc;
    logic [31:0] tag_in;
    logic        out_ready;

    logic        in_ready32, out_valid32, imm_err32;
    logic [31:0] ImmOp32, tag_out32;
    logic [7:0]  err_cnt32;
    logic        in_ready64, out_valid64, imm_err64;
    logic [63:0] ImmOp64;
    logic [31:0] tag_out64;
    logic [7:0]  err_cnt64;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   exp_cnt = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .ImmSrc(ImmSrc), .tag_in(tag_in),
        .out_valid(out_valid32), .out_ready(out_ready), .ImmOp(ImmOp32),
        .tag_out(tag_out32), .imm_err(imm_err32), .err_cnt(err_cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .ImmSrc(ImmSrc), .tag_in(tag_in),
        .out_valid(out_valid64), .out_ready(out_ready), .ImmOp(ImmOp64),
        .tag_out(tag_out64), .imm_err(imm_err64), .err_cnt(err_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    // Reference immediate, 64 bits wide; the XLEN=32 view is its low half
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            output logic err);
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [31:0] u32;
        longint      v;
        v   = 0;
        err = 1'b0;
        case (src)
            3'd0: begin i12 = ins[31:20];                 v = longint'($signed(i12)); end
            3'd1: begin i12 = {ins[31:25], ins[11:7]};    v = longint'($signed(i12)); end
            3'd2: begin b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                        v = longint'($signed(b13)); end
            3'd3: begin u32 = ins & 32'hFFFF_F000;        v = longint'($signed(u32)); end
            3'd4: begin j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                        v = longint'($signed(j21)); end
`ifdef IMMGEN_ZIMM_EN
            3'd5: v = longint'(ins[19:15]);
`endif
            default: err = 1'b1;
        endcase
        return 64'(v);
    endfunction

    task automatic check_outputs();
        chk("out_valid32", 64'(out_valid32), 64'(exp_q.size() > 0));
        chk("out_valid64", 64'(out_valid64), 64'(exp_q.size() > 0));
        chk("in_ready32", 64'(in_ready32), 64'(exp_q.size() < 2));
        chk("in_ready64", 64'(in_ready64), 64'(exp_q.size() < 2));
        chk("err_cnt32", 64'(err_cnt32), 64'(exp_cnt));
        chk("err_cnt64", 64'(err_cnt64), 64'(exp_cnt));
        if (exp_q.size() > 0) begin
            chk("imm32", 64'(ImmOp32), 64'(exp_q[0].imm[31:0]));
            chk("imm64", ImmOp64, exp_q[0].imm);
            chk("tag32", 64'(tag_out32), 64'(exp_q[0].tag));
            chk("tag64", 64'(tag_out64), 64'(exp_q[0].tag));
            chk("err32", 64'(imm_err32), 64'(exp_q[0].err));
            chk("err64", 64'(imm_err64), 64'(exp_q[0].err));
        end
    endtask

    // One cycle: drive inputs just after a falling edge, advance the model, check at the next falling edge
    task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] src,
                        input logic [31:0] tg, input logic ordy);
        exp_t it;
        logic e;
        logic acc;
        in_valid  = v;
        instr     = ins;
        ImmSrc    = src;
        tag_in    = tg;
        out_ready = ordy;
        acc = v && (exp_q.size() < 2);
        if ((exp_q.size() > 0) && ordy) it = exp_q.pop_front();
        if (acc) begin
            it.imm = ref_imm(ins, src, e);
            it.err = e;
            it.tag = tg;
            exp_q.push_back(it);
            if (e && (exp_cnt < 255)) exp_cnt++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; ImmSrc = '0; tag_in = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready", 64'(in_ready32), 64'd1);
        chk("rst_imm", ImmOp64, 64'd0);
        chk("rst_tag", 64'(tag_out32), 64'd0);
        chk("rst_imm_err", 64'(imm_err64), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt32), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known encodings, full throughput
        step(1'b1, 32'hFFF0_0093, 3'd0, 32'h10, 1'b1);
        chk("I_imm32", 64'(ImmOp32), 64'hFFFF_FFFF);
        chk("I_err", 64'(imm_err32), 64'd0);
        step(1'b1, 32'h8000_0863, 3'd2, 32'h11, 1'b1);
        chk("B_imm32", 64'(ImmOp32), 64'hFFFF_F010);
        step(1'b1, 32'h8000_02B7, 3'd3, 32'h12, 1'b1);
        chk("U_imm64", ImmOp64, 64'hFFFF_FFFF_8000_0000);
        step(1'b1, 32'h0040_006F, 3'd4, 32'h13, 1'b1);
        chk("J_imm64", ImmOp64, 64'h4);
        step(1'b1, 32'h000B_0073, 3'd5, 32'h14, 1'b1);
`ifdef IMMGEN_ZIMM_EN
        chk("Z_imm", 64'(ImmOp32), 64'd22);
        chk("Z_err", 64'(imm_err32), 64'd0);
`else
        chk("Z_imm", 64'(ImmOp32), 64'd0);
        chk("Z_err", 64'(imm_err32), 64'd1);
`endif
        step(1'b0, '0, 3'd0, '0, 1'b1);

        // Backpressure: tags 1,2 fill main and skid, tag 3 waits, then 1,2,3 drain back to back
        step(1'b1, $urandom, 3'd0, 32'd1, 1'b0);
        step(1'b1, $urandom, 3'd1, 32'd2, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
        step(1'b1, 32'h1234_5678, 3'd2, 32'd3, 1'b0);
        chk("bp_tag1", 64'(tag_out32), 64'd1);
        step(1'b1, 32'h1234_5678, 3'd2, 32'd3, 1'b1);
        chk("bp_tag2", 64'(tag_out32), 64'd2);
        chk("bp_valid2", 64'(out_valid32), 64'd1);
        step(1'b1, 32'h1234_5678, 3'd2, 32'd3, 1'b1);
        chk("bp_tag3", 64'(tag_out32), 64'd3);
        chk("bp_valid3", 64'(out_valid32), 64'd1);
        step(1'b0, '0, 3'd0, '0, 1'b1);

        // Reset while stalled with both entries holding bad-format items
        step(1'b1, $urandom, 3'd7, 32'hA, 1'b0);
        step(1'b1, $urandom, 3'd6, 32'hB, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid64), 64'd0);
        chk("midrst_in_ready", 64'(in_ready64), 64'd1);
        chk("midrst_err_cnt", 64'(err_cnt32), 64'd0);
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 3'd0, '0, 1'b1);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            step(1'b1, $urandom, 3'd7, 32'(i), 1'b1);
            chk("sat_imm", 64'(ImmOp32), 64'd0);
            chk("sat_err", 64'(imm_err32), 64'd1);
        end
        chk("sat_err_cnt", 64'(err_cnt64), 64'd255);
        step(1'b0, '0, 3'd0, '0, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom, 3'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 3'd0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
